// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter, data path has priority over instruction fetch
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iack,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dack,
  input  logic              halt,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, RESP, ERR} state_t;

  localparam logic [15:0]       TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_WORD  = DATA_W'(32'hBAD1BAD1);

  state_t            state_q, state_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_store_q, ram_store_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              iack_q, iack_d;
  logic              dack_q, dack_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic [15:0]       wd_cnt_q, wd_cnt_d;
  logic [15:0]       wd_cnt_inc;

  assign wd_cnt_inc = wd_cnt_q + 16'd1;

  // Grant, RAM handshake, watchdog and ack generation; every output is computed
  // one cycle ahead so it leaves the block straight from a flop.
  always_comb begin
    state_d     = state_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    iload_d     = iload_q;
    dload_d     = dload_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    err_d       = err_q;
    wr_d        = wr_q;
    wd_cnt_d    = wd_cnt_q;

    case (state_q)
      IDLE: begin
        wd_cnt_d = 16'd0;
        if (dREN || dWEN) begin
          // A simultaneous read and write request is treated as a write.
          state_d     = DBUSY;
          ram_addr_d  = daddr;
          ram_store_d = dstore;
          wr_d        = dWEN;
          ram_ren_d   = !dWEN;
          ram_wen_d   = dWEN;
        end else if (iREN && !halt) begin
          state_d    = IBUSY;
          ram_addr_d = iaddr;
          wr_d       = 1'b0;
          ram_ren_d  = 1'b1;
          ram_wen_d  = 1'b0;
        end
      end

      IBUSY, DBUSY: begin
        if (ram_ready) begin
          state_d   = RESP;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          wd_cnt_d  = 16'd0;
          if (state_q == IBUSY) begin
            iack_d  = 1'b1;
            iload_d = ramload;
          end else begin
            dack_d = 1'b1;
            if (!wr_q) dload_d = ramload;
          end
        end else if (wd_cnt_inc == TIMEOUT_C) begin
          // RAM never answered: release the bus, flag the error and give the
          // stuck requester a poisoned completion so it does not wait forever.
          state_d   = ERR;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          err_d     = 1'b1;
          wd_cnt_d  = 16'd0;
          if (state_q == IBUSY) begin
            iack_d  = 1'b1;
            iload_d = ERR_WORD;
          end else begin
            dack_d  = 1'b1;
            dload_d = ERR_WORD;
          end
        end else begin
          wd_cnt_d = wd_cnt_inc;
        end
      end

      RESP: begin
        state_d  = IDLE;
        wd_cnt_d = 16'd0;
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      wd_cnt_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign iack     = iack_q;
  assign dack     = dack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        iack, dack, ramREN, ramWEN, ram_ready, err;

  int checks   = 0;
  int failures = 0;
  int both_hi  = 0;
  int ram_waits = 0;
  logic ram_dead = 1'b0;
  int busy_cnt = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iack(iack),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dack(dack), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err)
  );

  // RAM model: fixed contents, ready after ram_waits strobe cycles
  always_comb begin
    ramload   = (ramaddr == 32'h40) ? 32'h3C010001 : {ramaddr[15:0], 16'h5A5A};
    ram_ready = (ramREN || ramWEN) && (busy_cnt >= ram_waits) && !ram_dead;
  end

  always @(posedge CLK) begin
    if (ramREN || ramWEN) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
    if (ramREN && ramWEN) both_hi <= both_hi + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; halt = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    tick(); tick();
    RST = 1'b0;
    checks++; if ({ramREN, ramWEN, iack, dack, err} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=00000", {ramREN, ramWEN, iack, dack, err}); end
    checks++; if ({ramaddr, ramstore, iload, dload} !== 128'b0) begin failures++;
      $display("FAIL reset_data got=%h exp=0", {ramaddr, ramstore, iload, dload}); end
  endtask

  task automatic test_fetch();
    iREN = 1; iaddr = 32'h40;
    tick();
    checks++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h40) begin failures++;
      $display("FAIL fetch_strobe got=%b addr=%h exp=10 addr=40", {ramREN, ramWEN}, ramaddr); end
    iREN = 0;
    tick();
    checks++; if (iack !== 1'b1 || iload !== 32'h3C010001 || dack !== 1'b0) begin failures++;
      $display("FAIL fetch_ack got iack=%b iload=%h dack=%b exp 1 3c010001 0", iack, iload, dack); end
    tick();
    checks++; if (iack !== 1'b0) begin failures++;
      $display("FAIL fetch_ack_pulse got=%b exp=0", iack); end
  endtask

  task automatic test_contention();
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100;
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin failures++;
      $display("FAIL cont_data_first got ren=%b addr=%h exp 1 100", ramREN, ramaddr); end
    dREN = 0;
    tick();
    checks++; if (dack !== 1'b1 || dload !== 32'h01005A5A || iack !== 1'b0) begin failures++;
      $display("FAIL cont_dack got dack=%b dload=%h iack=%b exp 1 01005a5a 0", dack, dload, iack); end
    tick();
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin failures++;
      $display("FAIL cont_fetch_grant got ren=%b addr=%h exp 1 80", ramREN, ramaddr); end
    iREN = 0;
    tick();
    checks++; if (iack !== 1'b1 || iload !== 32'h00805A5A) begin failures++;
      $display("FAIL cont_iack got iack=%b iload=%h exp 1 00805a5a", iack, iload); end
    tick();
  endtask

  task automatic test_store_waits();
    int good = 0;
    ram_waits = 4;
    dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    tick();
    dWEN = 0;
    for (int k = 0; k < 5; k++) begin
      if (ramWEN === 1'b1 && ramREN === 1'b0 && ramaddr === 32'h200 &&
          ramstore === 32'hDEADBEEF && dack === 1'b0) good++;
      tick();
    end
    checks++; if (good !== 5) begin failures++;
      $display("FAIL store_wen_cycles got=%0d exp=5", good); end
    checks++; if (dack !== 1'b1 || ramWEN !== 1'b0 || dload !== 32'h01005A5A) begin failures++;
      $display("FAIL store_dack got dack=%b wen=%b dload=%h exp 1 0 01005a5a", dack, ramWEN, dload); end
    ram_waits = 0;
    tick();
  endtask

  task automatic test_halt();
    int grants = 0;
    int got = 0;
    halt = 1; iREN = 1; iaddr = 32'h44;
    for (int k = 0; k < 20; k++) begin
      if (ramREN || ramWEN) grants++;
      tick();
    end
    checks++; if (grants !== 0) begin failures++;
      $display("FAIL halt_no_grant got=%0d exp=0", grants); end
    dREN = 1; daddr = 32'h300;
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin failures++;
      $display("FAIL halt_data_grant got ren=%b addr=%h exp 1 300", ramREN, ramaddr); end
    dREN = 0;
    tick();
    checks++; if (dack !== 1'b1 || dload !== 32'h03005A5A) begin failures++;
      $display("FAIL halt_dack got dack=%b dload=%h exp 1 03005a5a", dack, dload); end
    tick(); tick();
    checks++; if (ramREN !== 1'b0) begin failures++;
      $display("FAIL halt_still_blocked got=%b exp=0", ramREN); end
    // halt raised during a fetch in progress: the fetch still completes
    halt = 0; iaddr = 32'h40; ram_waits = 2;
    tick();
    iREN = 0; halt = 1;
    for (int k = 0; k < 6 && got == 0; k++) begin
      tick();
      if (iack === 1'b1 && iload === 32'h3C010001) got = 1;
    end
    checks++; if (got !== 1) begin failures++;
      $display("FAIL halt_inflight_fetch got=%0d exp=1", got); end
    halt = 0; ram_waits = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    int got = 0;
    ram_waits = 3;
    dREN = 1; daddr = 32'h104;
    tick();
    dREN = 0;
    tick();
    RST = 1;
    tick();
    RST = 0;
    checks++; if ({ramREN, ramWEN, dack} !== 3'b0) begin failures++;
      $display("FAIL rst_mid_strobes got=%b exp=000", {ramREN, ramWEN, dack}); end
    for (int k = 0; k < 5; k++) begin
      if (dack || iack) acks++;
      tick();
    end
    checks++; if (acks !== 0) begin failures++;
      $display("FAIL rst_mid_no_ack got=%0d exp=0", acks); end
    ram_waits = 0;
    iREN = 1; iaddr = 32'h40;
    tick();
    iREN = 0;
    for (int k = 0; k < 4 && got == 0; k++) begin
      tick();
      if (iack === 1'b1 && iload === 32'h3C010001) got = 1;
    end
    checks++; if (got !== 1) begin failures++;
      $display("FAIL rst_mid_fetch got=%0d exp=1", got); end
    tick();
  endtask

  task automatic test_watchdog();
    int early = 0;
    int acks = 0;
    int strobes = 0;
    int iacks = 0;
    logic [31:0] cap = 32'h0;
    ram_dead = 1;
    dREN = 1; daddr = 32'h108;
    tick();
    dREN = 0;
    for (int k = 0; k < 8; k++) begin
      if (err !== 1'b0) early++;
      if (dack) acks++;
      tick();
    end
    checks++; if (early !== 0) begin failures++;
      $display("FAIL wd_early_err got=%0d exp=0", early); end
    for (int k = 0; k < 4 && err !== 1'b1; k++) begin
      if (dack) begin acks++; cap = dload; end
      tick();
    end
    checks++; if (err !== 1'b1) begin failures++;
      $display("FAIL wd_err got=%b exp=1", err); end
    iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h10C;
    for (int k = 0; k < 10; k++) begin
      if (dack) begin acks++; cap = dload; end
      if (iack) iacks++;
      if (ramREN || ramWEN) strobes++;
      tick();
    end
    checks++; if (acks !== 1 || cap !== 32'hBAD1BAD1) begin failures++;
      $display("FAIL wd_ack got pulses=%0d dload=%h exp 1 bad1bad1", acks, cap); end
    checks++; if (strobes !== 0 || iacks !== 0 || err !== 1'b1) begin failures++;
      $display("FAIL wd_hold got strobes=%0d iacks=%0d err=%b exp 0 0 1", strobes, iacks, err); end
    iREN = 0; dREN = 0; ram_dead = 0;
    RST = 1;
    tick();
    RST = 0;
    checks++; if (err !== 1'b0) begin failures++;
      $display("FAIL wd_rst_clear got=%b exp=0", err); end
    iREN = 1; iaddr = 32'h40;
    tick();
    iREN = 0;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin failures++;
      $display("FAIL wd_after_rst_grant got ren=%b addr=%h exp 1 40", ramREN, ramaddr); end
    tick();
    checks++; if (iack !== 1'b1 || iload !== 32'h3C010001) begin failures++;
      $display("FAIL wd_after_rst_iack got iack=%b iload=%h exp 1 3c010001", iack, iload); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store_waits();
    test_halt();
    test_reset_mid();
    test_watchdog();
    checks++; if (both_hi !== 0) begin failures++;
      $display("FAIL strobes_exclusive got=%0d exp=0", both_hi); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
